output_shuffle: RTL and testbench
=================================

OUTPUT_SHUFFLE -- requirements
Module: output_shuffle

Interface
REQ-001 The parameter SEED SHALL default to 16'hACE1 and set the LFSR reset value; a value of 0 SHALL be replaced by 16'h0001.
REQ-002 The parameter HOLD SHALL default to 1 and set the number of dt cycles each selection value is held; legal range is 1..65535.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 Port dt SHALL be an input, 1 bit wide: the single clock, sampled on rising edges.
REQ-005 Port rst SHALL be an input, 1 bit wide: synchronous, active-high reset.
REQ-006 Port selection SHALL be an output, 4 bits wide: the current shuffled output-channel index (0..15).

Function
REQ-007 The block SHALL hold a 16-bit Fibonacci LFSR (lfsr), a 4-bit index counter (idx) and a 16-bit hold prescaler (pre).
REQ-008 LFSR step SHALL be fb = lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10], then lfsr <= {lfsr[14:0], fb}, giving maximal length 65535 with no zero state.
REQ-009 An "advance" SHALL occur on a rising edge of dt when pre == HOLD-1; pre SHALL then reset to 0, otherwise pre increments by 1.
REQ-010 On each advance, idx SHALL increment modulo 16.
REQ-011 On an advance where idx wraps from 15 to 0, the LFSR SHALL step exactly once; the LFSR SHALL never step at any other time.
REQ-012 key = lfsr[3:0] and rot = lfsr[5:4] SHALL define the current round.
REQ-013 selection SHALL equal rotate-left-by-rot of (idx XOR key), taken over 4 bits.
REQ-014 selection SHALL be derived only from registered state, with no combinational path from any input, and SHALL change only on rising edges of dt.
REQ-015 Each round of 16 consecutive advances SHALL emit every value 0..15 exactly once; this follows because the mapping in REQ-013 is a bijection.
REQ-016 With HOLD=1, selection SHALL change on every dt cycle, so the latency from advance to new output is 0 cycles after the edge.
REQ-017 There SHALL be no handshake; the block SHALL free-run whenever rst is low.

Reset
REQ-018 When rst is high at a rising edge of dt, the block SHALL load lfsr <= SEED (or 16'h0001 if SEED is 0), idx <= 0 and pre <= 0.
REQ-019 After reset with the default SEED, selection SHALL be 4 (key=1, rot=2).
REQ-020 Reset SHALL override an advance occurring on the same edge, and asserting reset mid-round SHALL restart the round from idx=0.
REQ-021 Before the first reset, outputs SHALL be undefined; the bench SHALL apply reset for at least 1 cycle.

Verification
REQ-022 Default parameters, 1-cycle reset, then free run: selection SHALL be 4,0,12,8,5,1,13,9,6,2,14,10,7,3,15,11 on consecutive cycles.
REQ-023 Continue after that 16th value: the LFSR SHALL step to 16'h59C3 (key=3, rot=0), and the next round SHALL be 3,2,1,0,7,6,5,4,11,10,9,8,15,14,13,12.
REQ-024 HOLD=4, after reset: selection SHALL be 4 for 4 cycles, then 0 for 4 cycles, then 12, and so on.
REQ-025 rst asserted for 1 cycle after the 7th value of a round: the next value SHALL be 4, and the SEED round SHALL replay from its start.
REQ-026 300 dt half-periods (150 cycles), checked per round: each 16-value window aligned to round start SHALL contain all values 0..15 exactly once.
REQ-027 SEED=0: after reset, lfsr SHALL be 16'h0001 and selection SHALL be 1, followed by 0,3,2,5,4 and onward.

Source files
------------

// File: rtl/output_shuffle.sv
// Output-channel shuffler: walks idx 0..15 through a per-round bijection
// (XOR key, then rotate) whose key/rotation come from a 16-bit LFSR stepped once per round.
module output_shuffle #(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter int unsigned HOLD = 1
) (
  input  logic       dt,
  input  logic       rst,
  output logic [3:0] selection
);

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] HOLD_LAST = 16'(HOLD - 32'd1);

  logic [15:0] lfsr_r;
  logic [3:0]  idx_r;
  logic [15:0] pre_r;
  logic [3:0]  selection_r;

  logic        advance_s;
  logic [15:0] lfsr_next_s;
  logic [3:0]  idx_next_s;
  logic [15:0] pre_next_s;

  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    logic fb;
    fb = cur[15] ^ cur[13] ^ cur[12] ^ cur[10];
    return {cur[14:0], fb};
  endfunction

  // low[3:0] is the XOR key, low[5:4] the left-rotate amount.
  function automatic logic [3:0] shuffle_map(input logic [3:0] idx, input logic [5:0] low);
    logic [3:0] x;
    logic [3:0] r;
    x = idx ^ low[3:0];
    case (low[5:4])
      2'd0:    r = x;
      2'd1:    r = {x[2:0], x[3]};
      2'd2:    r = {x[1:0], x[3:2]};
      2'd3:    r = {x[0], x[3:1]};
      default: r = x;
    endcase
    return r;
  endfunction

  // Next-state: prescaler, index and once-per-round LFSR step.
  always_comb begin
    advance_s   = (pre_r == HOLD_LAST);
    lfsr_next_s = lfsr_r;
    idx_next_s  = idx_r;
    pre_next_s  = pre_r + 16'd1;
    if (advance_s) begin
      pre_next_s = 16'd0;
      idx_next_s = idx_r + 4'd1;
      if (idx_r == 4'd15) begin
        lfsr_next_s = lfsr_step(lfsr_r);
      end else begin
        lfsr_next_s = lfsr_r;
      end
    end else begin
      pre_next_s = pre_r + 16'd1;
    end
  end

  // State registers; selection is registered from the next-state values so it
  // updates on the same edge as idx/lfsr.
  always_ff @(posedge dt) begin
    if (rst) begin
      lfsr_r      <= SEED_EFF;
      idx_r       <= 4'd0;
      pre_r       <= 16'd0;
      selection_r <= shuffle_map(4'd0, SEED_EFF[5:0]);
    end else begin
      lfsr_r      <= lfsr_next_s;
      idx_r       <= idx_next_s;
      pre_r       <= pre_next_s;
      selection_r <= shuffle_map(idx_next_s, lfsr_next_s[5:0]);
    end
  end

  assign selection = selection_r;

endmodule

// File: tb/tb_output_shuffle.sv
// Self-checking bench for output_shuffle: default, HOLD=4 and SEED=0 instances
// compared against an arithmetic reference model plus fixed expected sequences.
module tb_output_shuffle;

  logic       dt = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sel_a;
  logic [3:0] sel_b;
  logic [3:0] sel_c;

  int errors = 0;
  int checks = 0;

  always #5 dt = ~dt;

  output_shuffle u_def (.dt(dt), .rst(rst), .selection(sel_a));
  output_shuffle #(.HOLD(4)) u_hold4 (.dt(dt), .rst(rst), .selection(sel_b));
  output_shuffle #(.SEED(16'h0000)) u_seed0 (.dt(dt), .rst(rst), .selection(sel_c));

  int m_lfsr[3];
  int m_idx[3];
  int m_pre[3];
  int hold_k[3] = '{1, 4, 1};
  int seed_k[3] = '{16'hACE1, 16'hACE1, 16'h0001};

  logic [3:0] exp0[16] = '{4'd4, 4'd0, 4'd12, 4'd8, 4'd5, 4'd1, 4'd13, 4'd9,
                           4'd6, 4'd2, 4'd14, 4'd10, 4'd7, 4'd3, 4'd15, 4'd11};
  logic [3:0] exp1[16] = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd7, 4'd6, 4'd5, 4'd4,
                           4'd11, 4'd10, 4'd9, 4'd8, 4'd15, 4'd14, 4'd13, 4'd12};
  logic [3:0] exp_s0[6] = '{4'd1, 4'd0, 4'd3, 4'd2, 4'd5, 4'd4};

  function automatic int model_sel(int k);
    int key, rot, x;
    key = m_lfsr[k] % 16;
    rot = (m_lfsr[k] / 16) % 4;
    x   = m_idx[k] ^ key;
    return ((x * (1 << rot)) % 16) + (x / (1 << (4 - rot)));
  endfunction

  function automatic int next_lfsr(int l);
    int fb;
    fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
    return ((l * 2) + fb) % 65536;
  endfunction

  function automatic logic [3:0] observed(int k);
    case (k)
      0:       return sel_a;
      1:       return sel_b;
      default: return sel_c;
    endcase
  endfunction

  // One dt cycle: drive rst, advance the model at the edge, return at the falling edge.
  task automatic step(input logic r);
    rst = r;
    @(posedge dt);
    for (int k = 0; k < 3; k++) begin
      if (r) begin
        m_lfsr[k] = seed_k[k];
        m_idx[k]  = 0;
        m_pre[k]  = 0;
      end else if (m_pre[k] == hold_k[k] - 1) begin
        m_pre[k] = 0;
        if (m_idx[k] == 15) m_lfsr[k] = next_lfsr(m_lfsr[k]);
        m_idx[k] = (m_idx[k] + 1) % 16;
      end else begin
        m_pre[k] = m_pre[k] + 1;
      end
    end
    @(negedge dt);
  endtask

  task automatic test_reset();
    step(1'b1);
    checks++;
    if (sel_a !== 4'd4) begin
      errors++;
      $display("FAIL reset_default got=%0d want=4", sel_a);
    end
    checks++;
    if (sel_b !== 4'd4) begin
      errors++;
      $display("FAIL reset_hold4 got=%0d want=4", sel_b);
    end
    checks++;
    if (sel_c !== 4'd1) begin
      errors++;
      $display("FAIL reset_seed0 got=%0d want=1", sel_c);
    end
    checks++;
    if (u_seed0.lfsr_r !== 16'h0001) begin
      errors++;
      $display("FAIL reset_seed0_lfsr got=%h want=0001", u_seed0.lfsr_r);
    end
  endtask

  task automatic test_rounds();
    step(1'b1);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) step(1'b0);
      checks++;
      if (sel_a !== exp0[i]) begin
        errors++;
        $display("FAIL round0[%0d] got=%0d want=%0d", i, sel_a, exp0[i]);
      end
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0);
      checks++;
      if (sel_a !== exp1[i]) begin
        errors++;
        $display("FAIL round1[%0d] got=%0d want=%0d", i, sel_a, exp1[i]);
      end
    end
    checks++;
    if (u_def.lfsr_r !== 16'h59C3) begin
      errors++;
      $display("FAIL lfsr_after_round got=%h want=59c3", u_def.lfsr_r);
    end
  endtask

  task automatic test_hold4();
    step(1'b1);
    for (int c = 0; c < 16; c++) begin
      if (c > 0) step(1'b0);
      checks++;
      if (sel_b !== exp0[c / 4]) begin
        errors++;
        $display("FAIL hold4[%0d] got=%0d want=%0d", c, sel_b, exp0[c / 4]);
      end
    end
  endtask

  task automatic test_seed0();
    step(1'b1);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step(1'b0);
      checks++;
      if (sel_c !== exp_s0[i]) begin
        errors++;
        $display("FAIL seed0[%0d] got=%0d want=%0d", i, sel_c, exp_s0[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    step(1'b1);
    for (int i = 1; i < 7; i++) step(1'b0);
    step(1'b1);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step(1'b0);
      checks++;
      if (sel_a !== exp0[i]) begin
        errors++;
        $display("FAIL mid_reset[%0d] got=%0d want=%0d", i, sel_a, exp0[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] mask;
    int          cnt;
    logic        r;
    step(1'b1);
    mask = 16'h0001 << sel_a;
    cnt  = 1;
    for (int c = 0; c < 150; c++) begin
      r = ($urandom_range(0, 39) == 0);
      step(r);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (observed(k) !== 4'(model_sel(k))) begin
          errors++;
          $display("FAIL random_model inst=%0d cyc=%0d got=%0d want=%0d",
                   k, c, observed(k), model_sel(k));
        end
      end
      if (r || m_idx[0] == 0) begin
        mask = 16'h0001 << sel_a;
        cnt  = 1;
      end else begin
        mask = mask | (16'h0001 << sel_a);
        cnt  = cnt + 1;
      end
      if (m_idx[0] == 15 && cnt == 16) begin
        checks++;
        if (mask !== 16'hFFFF) begin
          errors++;
          $display("FAIL round_permutation cyc=%0d got=%h want=ffff", c, mask);
        end
      end
    end
  endtask

  initial begin
    @(negedge dt);
    test_reset();
    test_rounds();
    test_hold4();
    test_seed0();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
